// File: rtl/mem_wb_stage.sv
// Memory-access stage and MEM/WB pipeline register.
// Optional stuck-access timeout: define MEM_WB_TIMEOUT_EN.
module mem_wb_stage #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        d_ren_i,
  input  logic        d_wen_i,
  input  logic [31:0] dmemaddr_i,
  input  logic [31:0] dmemstore_i,
  input  logic        wen_i,
  input  logic [4:0]  wsel_i,
  input  logic [2:0]  wmux_i,
  input  logic [31:0] lui_i,
  input  logic [31:0] npc_i,
  input  logic [31:0] imemload_i,
  input  logic        halt_i,
  input  logic        wb_flush,
  input  logic        dhit,
  input  logic [31:0] dmemload,
  output logic        dREN,
  output logic        dWEN,
  output logic [31:0] daddr,
  output logic [31:0] dstore,
  output logic        mem_stall,
  output logic        wb_wen,
  output logic [4:0]  wb_wsel,
  output logic [2:0]  wb_wmux,
  output logic [31:0] wb_alu,
  output logic [31:0] wb_lui,
  output logic [31:0] wb_npc,
  output logic [31:0] wb_dmemload,
  output logic [31:0] wb_imemload,
  output logic        wb_halt,
  output logic        mem_err
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    HALTED
  } state_t;

  typedef struct packed {
    logic        wen;
    logic [4:0]  wsel;
    logic [2:0]  wmux;
    logic [31:0] alu;
    logic [31:0] lui;
    logic [31:0] npc;
    logic [31:0] dload;
    logic [31:0] iload;
    logic        halt;
  } mem_wb_t;

  state_t  state;
  mem_wb_t wb_q;
  mem_wb_t wb_d;
  logic    req;
  logic    tmo;
  logic    stall;
  logic    capture;

  // Reset drops the request in the same cycle it is raised
  assign req = (d_ren_i | d_wen_i) & (state != HALTED) & ~RST;

  assign dWEN   = req & d_wen_i;
  assign dREN   = req & d_ren_i & ~d_wen_i;
  assign daddr  = req ? dmemaddr_i : '0;
  assign dstore = req ? dmemstore_i : '0;

`ifdef MEM_WB_TIMEOUT_EN
  logic [7:0] cnt;
  assign tmo = (state == WAIT) & req & ~dhit &
               (cnt == 8'(TIMEOUT_CYCLES - 1));
`else
  logic unused_timeout;
  assign unused_timeout = ^8'(TIMEOUT_CYCLES);
  assign tmo = 1'b0;
  assign mem_err = 1'b0;
`endif

  assign stall     = req & ~dhit & ~tmo;
  assign mem_stall = stall;
  assign capture   = ~wb_flush & ~stall & (state != HALTED);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
`ifdef MEM_WB_TIMEOUT_EN
      cnt     <= '0;
      mem_err <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (capture & halt_i)
            state <= HALTED;
          else if (stall)
            state <= WAIT;
        end
        WAIT: begin
          if (capture & halt_i)
            state <= HALTED;
          else if (~stall)
            state <= IDLE;
        end
        HALTED: state <= HALTED;
        default: state <= IDLE;
      endcase
`ifdef MEM_WB_TIMEOUT_EN
      cnt     <= (state == WAIT) ? cnt + 8'd1 : '0;
      mem_err <= mem_err | tmo;
`endif
    end
  end

  always_comb begin
    wb_d       = '0;
    wb_d.wen   = wen_i;
    wb_d.wsel  = wsel_i;
    wb_d.wmux  = wmux_i;
    wb_d.alu   = dmemaddr_i;
    wb_d.lui   = lui_i;
    wb_d.npc   = npc_i;
    wb_d.dload = (dREN & ~tmo) ? dmemload : '0;
    wb_d.iload = imemload_i;
    wb_d.halt  = halt_i;
  end

  // Stalled cycles write a bubble so WB never repeats a write
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)
      wb_q <= '0;
    else if (state != HALTED)
      wb_q <= (wb_flush | stall) ? '0 : wb_d;
  end

  assign wb_wen      = wb_q.wen;
  assign wb_wsel     = wb_q.wsel;
  assign wb_wmux     = wb_q.wmux;
  assign wb_alu      = wb_q.alu;
  assign wb_lui      = wb_q.lui;
  assign wb_npc      = wb_q.npc;
  assign wb_dmemload = wb_q.dload;
  assign wb_imemload = wb_q.iload;
  assign wb_halt     = wb_q.halt;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Scoreboard bench for mem_wb_stage.
// Reference model works per instruction from the stage rules.
module tb_mem_wb_stage;

`ifdef MEM_WB_TIMEOUT_EN
  localparam int TO    = 4;
  localparam bit TO_EN = 1'b1;
`else
  localparam int TO    = 255;
  localparam bit TO_EN = 1'b0;
`endif

  logic        CLK;
  logic        RST;
  logic        d_ren_i, d_wen_i;
  logic [31:0] dmemaddr_i, dmemstore_i;
  logic        wen_i;
  logic [4:0]  wsel_i;
  logic [2:0]  wmux_i;
  logic [31:0] lui_i, npc_i, imemload_i;
  logic        halt_i, wb_flush, dhit;
  logic [31:0] dmemload;
  logic        dREN, dWEN;
  logic [31:0] daddr, dstore;
  logic        mem_stall;
  logic        wb_wen;
  logic [4:0]  wb_wsel;
  logic [2:0]  wb_wmux;
  logic [31:0] wb_alu, wb_lui, wb_npc;
  logic [31:0] wb_dmemload, wb_imemload;
  logic        wb_halt, mem_err;

  mem_wb_stage #(.TIMEOUT_CYCLES(TO)) dut (
    .CLK(CLK), .RST(RST),
    .d_ren_i(d_ren_i), .d_wen_i(d_wen_i),
    .dmemaddr_i(dmemaddr_i), .dmemstore_i(dmemstore_i),
    .wen_i(wen_i), .wsel_i(wsel_i), .wmux_i(wmux_i),
    .lui_i(lui_i), .npc_i(npc_i), .imemload_i(imemload_i),
    .halt_i(halt_i), .wb_flush(wb_flush),
    .dhit(dhit), .dmemload(dmemload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .mem_stall(mem_stall),
    .wb_wen(wb_wen), .wb_wsel(wb_wsel), .wb_wmux(wb_wmux),
    .wb_alu(wb_alu), .wb_lui(wb_lui), .wb_npc(wb_npc),
    .wb_dmemload(wb_dmemload), .wb_imemload(wb_imemload),
    .wb_halt(wb_halt), .mem_err(mem_err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct packed {
    logic        wen;
    logic [4:0]  wsel;
    logic [2:0]  wmux;
    logic [31:0] alu;
    logic [31:0] lui;
    logic [31:0] npc;
    logic [31:0] dload;
    logic [31:0] iload;
    logic        halt;
  } wb_t;

  typedef struct packed {
    logic        ren;
    logic        wen;
    logic [31:0] addr;
    logic [31:0] store;
    logic        wr;
    logic [4:0]  wsel;
    logic [2:0]  wmux;
    logic [31:0] lui;
    logic [31:0] npc;
    logic [31:0] iload;
    logic        halt;
  } instr_t;

  typedef struct packed {
    logic        dren;
    logic        dwen;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic        stall;
    logic        err;
    wb_t         wb;
  } exp_t;

  exp_t q[$];
  int   vectors = 0;
  int   miscompares = 0;

  bit   m_halt;
  bit   m_err;
  int   m_wait;
  wb_t  m_wb;
  bit   last_stall;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: one expectation per cycle, sampled mid-cycle
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("dREN", 32'(dREN), 32'(e.dren));
        chk("dWEN", 32'(dWEN), 32'(e.dwen));
        chk("daddr", daddr, e.daddr);
        chk("dstore", dstore, e.dstore);
        chk("mem_stall", 32'(mem_stall), 32'(e.stall));
        chk("mem_err", 32'(mem_err), 32'(e.err));
        chk("wb_wen", 32'(wb_wen), 32'(e.wb.wen));
        chk("wb_wsel", 32'(wb_wsel), 32'(e.wb.wsel));
        chk("wb_wmux", 32'(wb_wmux), 32'(e.wb.wmux));
        chk("wb_alu", wb_alu, e.wb.alu);
        chk("wb_lui", wb_lui, e.wb.lui);
        chk("wb_npc", wb_npc, e.wb.npc);
        chk("wb_dmemload", wb_dmemload, e.wb.dload);
        chk("wb_imemload", wb_imemload, e.wb.iload);
        chk("wb_halt", 32'(wb_halt), 32'(e.wb.halt));
      end
    end
  end

  // Drive one cycle and predict what the stage shows during it
  task automatic step(bit rst, instr_t in, bit fl, bit hit,
                      logic [31:0] ld);
    exp_t e;
    bit   req;
    bit   tmo;
    @(posedge CLK);
    #1;
    RST         = rst;
    d_ren_i     = in.ren;
    d_wen_i     = in.wen;
    dmemaddr_i  = in.addr;
    dmemstore_i = in.store;
    wen_i       = in.wr;
    wsel_i      = in.wsel;
    wmux_i      = in.wmux;
    lui_i       = in.lui;
    npc_i       = in.npc;
    imemload_i  = in.iload;
    halt_i      = in.halt;
    wb_flush    = fl;
    dhit        = hit;
    dmemload    = ld;
    if (rst) begin
      m_halt = 0;
      m_err  = 0;
      m_wait = 0;
      m_wb   = '0;
    end
    req = (in.ren || in.wen) && !m_halt && !rst;
    e.dwen   = req && in.wen;
    e.dren   = req && in.ren && !in.wen;
    e.daddr  = req ? in.addr : 32'h0;
    e.dstore = req ? in.store : 32'h0;
    tmo = TO_EN && req && !hit && (m_wait == TO);
    e.stall = req && !hit && !tmo;
    e.err   = m_err;
    e.wb    = m_wb;
    q.push_back(e);
    last_stall = e.stall;
    if (!rst) begin
      if (!m_halt) begin
        if (fl || e.stall) begin
          m_wb = '0;
        end else begin
          m_wb.wen   = in.wr;
          m_wb.wsel  = in.wsel;
          m_wb.wmux  = in.wmux;
          m_wb.alu   = in.addr;
          m_wb.lui   = in.lui;
          m_wb.npc   = in.npc;
          m_wb.dload = (e.dren && !tmo) ? ld : 32'h0;
          m_wb.iload = in.iload;
          m_wb.halt  = in.halt;
          m_halt     = in.halt;
        end
      end
      m_err  = m_err || tmo;
      m_wait = e.stall ? m_wait + 1 : 0;
    end
  endtask

  task automatic do_reset();
    step(1'b1, '0, 1'b0, 1'b0, 32'h0);
  endtask

  // Present one instruction, holding it for as long as it stalls
  task automatic run_instr(instr_t in, int lat, int fl_pct, int rst_at,
                           logic [31:0] ld, bit rnd_ld);
    bit          mem;
    bit          hit;
    bit          fl;
    bit          r;
    logic [31:0] data;
    mem = in.ren || in.wen;
    for (int c = 0; c < 400; c++) begin
      hit  = mem ? (c == lat) : 1'($urandom_range(0, 1));
      fl   = ($urandom_range(0, 99) < fl_pct);
      r    = (c == rst_at);
      data = rnd_ld ? $urandom : ld;
      step(r, in, fl, hit, data);
      if (r || !last_stall)
        return;
    end
    vectors++;
    miscompares++;
    $display("FAIL stall_bound: still stalled after 400 cycles");
  endtask

  function automatic instr_t rand_instr();
    instr_t in;
    int     kind;
    kind     = $urandom_range(0, 3);
    in.ren   = (kind == 1) || (kind == 3);
    in.wen   = (kind == 2) || (kind == 3);
    in.addr  = $urandom;
    in.store = $urandom;
    in.wr    = 1'($urandom_range(0, 1));
    in.wsel  = 5'($urandom);
    in.wmux  = 3'($urandom);
    in.lui   = $urandom;
    in.npc   = $urandom;
    in.iload = $urandom;
    in.halt  = ($urandom_range(0, 29) == 0);
    return in;
  endfunction

  initial begin
    instr_t in;
    int     lat;
    int     rst_at;
    RST = 1'b1;
    {d_ren_i, d_wen_i, wen_i, halt_i, wb_flush, dhit} = '0;
    {dmemaddr_i, dmemstore_i, lui_i, npc_i, imemload_i, dmemload} = '0;
    wsel_i = '0;
    wmux_i = '0;
    m_halt = 0;
    m_err  = 0;
    m_wait = 0;
    m_wb   = '0;
    do_reset();
    do_reset();

    // Load with three cycles of cache latency
    in = rand_instr();
    in.ren = 1; in.wen = 0; in.wr = 1; in.halt = 0;
    in.addr = 32'h100;
    run_instr(in, 3, 0, -1, 32'hDEADBEEF, 1'b0);

    // Zero-wait store
    in = rand_instr();
    in.ren = 0; in.wen = 1; in.halt = 0;
    run_instr(in, 0, 0, -1, 32'h0, 1'b1);

    // Load and store together: store wins
    in = rand_instr();
    in.ren = 1; in.wen = 1; in.halt = 0;
    run_instr(in, 1, 0, -1, 32'h0, 1'b1);

    // Flushes while waiting on the cache
    in = rand_instr();
    in.ren = 1; in.wen = 0; in.halt = 0;
    run_instr(in, 3, 50, -1, 32'h0, 1'b1);

    // Reset in the middle of an access
    in = rand_instr();
    in.ren = 1; in.wen = 0; in.halt = 0;
    run_instr(in, 3, 0, 2, 32'h0, 1'b1);
    run_instr('0, 0, 0, -1, 32'h0, 1'b1);

    // Halting ALU op followed by a masked load
    in = rand_instr();
    in.ren = 0; in.wen = 0; in.halt = 1; in.wr = 1;
    run_instr(in, 0, 0, -1, 32'h0, 1'b1);
    in = rand_instr();
    in.ren = 1; in.wen = 0; in.halt = 0;
    run_instr(in, 0, 0, -1, 32'h0, 1'b1);
    run_instr(rand_instr(), 0, 30, -1, 32'h0, 1'b1);
    run_instr(rand_instr(), 0, 0, -1, 32'h0, 1'b1);
    do_reset();

`ifdef MEM_WB_TIMEOUT_EN
    // Cache never answers
    in = rand_instr();
    in.ren = 1; in.wen = 0; in.halt = 0;
    run_instr(in, 1000, 0, -1, 32'h0, 1'b1);
    run_instr(rand_instr(), 0, 0, -1, 32'h0, 1'b1);
    run_instr(rand_instr(), 2, 0, -1, 32'h0, 1'b1);
    do_reset();
`endif

    for (int n = 0; n < 400; n++) begin
      in  = rand_instr();
      lat = $urandom_range(0, 3);
      if (TO_EN && $urandom_range(0, 9) == 0)
        lat = 1000;
      rst_at = ($urandom_range(0, 19) == 0) ?
               int'($urandom_range(0, 3)) : -1;
      run_instr(in, lat, 10, rst_at, 32'h0, 1'b1);
      if (m_halt && $urandom_range(0, 3) == 0)
        do_reset();
    end

    run_instr('0, 0, 0, -1, 32'h0, 1'b1);
    run_instr('0, 0, 0, -1, 32'h0, 1'b1);
    @(negedge CLK);
    @(negedge CLK);
    if (q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL scoreboard_drain: %0d left, 0 required", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_wb_stage.md
# mem_wb_stage

Memory-access stage and MEM/WB pipeline register of the five-stage core. Consumes the registered EX/MEM fields, issues the data-cache request, and holds the front of the pipeline via `mem_stall` until `dhit` arrives. Writes the completed result (load data, ALU/LUI/npc candidates, write-back controls) into the MEM/WB register that feeds write-back.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, 255: maximum wait cycles before a stuck access is abandoned; range 1-255. Used only with `MEM_WB_TIMEOUT_EN`.

Ports:
- `CLK`  in  1  clock; all state changes on the rising edge.
- `RST`  in  1  reset, asynchronous, active-high.
- `d_ren_i`, `d_wen_i`  in  1 each  load/store request from EX/MEM.
- `dmemaddr_i`  in  32  data address and ALU result.
- `dmemstore_i`  in  32  store data.
- `wen_i`  in  1, `wsel_i`  in  5, `wmux_i`  in  3  register write-back controls.
- `lui_i`, `npc_i`, `imemload_i`  in  32 each  write-back candidates and trace word.
- `halt_i`  in  1  halt marker.
- `wb_flush`  in  1  synchronous bubble insert into MEM/WB.
- `dhit`  in  1  data cache completion; `dmemload`  in  32  load data.
- `dREN`, `dWEN`  out  1 each; `daddr`, `dstore`  out  32 each  cache request.
- `mem_stall`  out  1  when high, upstream pipe enables are deasserted.
- `wb_wen`, `wb_wsel`(5), `wb_wmux`(3), `wb_alu`(32), `wb_lui`(32), `wb_npc`(32), `wb_dmemload`(32), `wb_imemload`(32), `wb_halt`(1)  out  registered MEM/WB fields.
- `mem_err`  out  1  sticky timeout flag.

## Operation
- `req = (d_ren_i | d_wen_i) & state != HALTED`. If both are set, the write wins: `dWEN=1`, `dREN=0`.
- `dREN`/`dWEN`/`daddr`/`dstore` are combinational from the inputs while `req` is set. They are 0 otherwise.
- `mem_stall = req & !dhit` (plus the timeout override, below).
- FSM states:
  - IDLE: on `req & !dhit`, go to WAIT. On `req & dhit`, stay in IDLE (zero-wait access).
  - WAIT: on `dhit`, go to IDLE.
  - HALTED: entered when a `halt_i=1` instruction is written into MEM/WB. Left only by `RST`. All requests are masked, `mem_stall=0`, and the MEM/WB register holds.
- MEM/WB update on each edge, in priority order:
  - `wb_flush`: write bubble (all fields 0).
  - else `mem_stall`: write bubble, so WB never repeats a write.
  - else: capture the inputs. `wb_alu <= dmemaddr_i`. `wb_dmemload <= dmemload` when `dREN` was 1, else 0.
- While `mem_stall` is high, all inputs are guaranteed stable because EX/MEM holds.

## Timing
- Reset values: state IDLE; all `wb_*` 0; `mem_err` 0; wait counter 0.
- Request outputs are combinational in the same cycle EX/MEM presents the instruction.
- Wait behaviour: N cycles of `dhit` latency give N cycles of `mem_stall`. The instruction reaches MEM/WB at the edge ending the `dhit` cycle.
- A non-memory instruction reaches MEM/WB one edge after presentation.
- `dhit` without `req` is ignored.
- `RST` mid-access: immediately returns to IDLE, clears all outputs, and drops the request.
- `wb_flush` while in WAIT: the bubble is written, and the FSM still waits for `dhit`.

## Configuration
- `MEM_WB_TIMEOUT_EN` defined:
  - An 8-bit counter increments each WAIT cycle and clears in IDLE.
  - When a WAIT cycle is reached with count `TIMEOUT_CYCLES-1` and no `dhit`, the access is abandoned: `mem_stall` drops that cycle, the instruction is captured with `wb_dmemload=0`, `mem_err` is set (sticky until `RST`), and the FSM returns to IDLE.
- Not defined: no counter; `mem_err` is tied 0; WAIT is held indefinitely.

## Test plan
- Load, `dmemaddr_i=0x100`, `dhit` 3 cycles later with `dmemload=0xDEADBEEF`: `dREN=1` for 4 cycles, `mem_stall` high 3 cycles, then `wb_dmemload=0xDEADBEEF`, `wb_wen=1`. Bubbles (`wb_wen=0`) during the stall.
- Store with `dhit` same cycle: `dWEN=1`, `daddr`/`dstore` match the inputs, `mem_stall` never high, `wb_dmemload=0`.
- `d_ren_i=d_wen_i=1`: `dWEN=1`, `dREN=0`.
- `halt_i=1` ALU instruction followed by a load: `wb_halt=1`; the later load produces no `dREN` and MEM/WB holds until `RST`.
- Assert `RST` during WAIT: all outputs are 0 the same cycle, and the FSM is in IDLE after release.
- With `MEM_WB_TIMEOUT_EN` and `TIMEOUT_CYCLES=4`, never assert `dhit`: `mem_stall` drops after 4 cycles, `mem_err=1`, `wb_dmemload=0`.
